// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among 8 requesters.
// Drives the decoder selects and also exports a registered one-hot grant.
module rr_decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       sel_x,
    output logic       sel_y,
    output logic       sel_z,
    output logic       sel_en,
    output logic       preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // With pre-emption disabled the counter simply saturates at its maximum.
    localparam logic [7:0] HOLD_LIMIT = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD - 1);
    localparam logic       PREEMPT_EN = (MAX_HOLD != 0);

    state_e     state_q, state_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic       preempt_q, preempt_d;

    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  rot_pos;
    logic [2:0]  winner;
    logic        holder_req;
    logic        others_req;

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[ptr_q +: 8];
        rot_pos = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_pos = 3'(i);
            end
        end
        winner = ptr_q + rot_pos;
    end

    assign holder_req = req[gnt_idx_q];
    assign others_req = |(req & ~(8'd1 << gnt_idx_q));

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        preempt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANT;
                    gnt_idx_d   = winner;
                    gnt_valid_d = 1'b1;
                    hold_d      = 8'd0;
                end
            end
            GRANT: begin
                // Release wins over pre-emption, so preempt only fires while the holder still asks.
                if (!holder_req) begin
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 3'd1;
                end else if (PREEMPT_EN && (hold_q == HOLD_LIMIT) && others_req) begin
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 3'd1;
                    preempt_d   = 1'b1;
                end else if (hold_q != HOLD_LIMIT) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
        assign gnt_d[gi] = gnt_valid_d && (gnt_idx_d == 3'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            gnt_q       <= 8'd0;
            ptr_q       <= 3'd0;
            hold_q      <= 8'd0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign sel_x     = gnt_idx_q[2];
    assign sel_y     = gnt_idx_q[1];
    assign sel_z     = gnt_idx_q[0];
    assign sel_en    = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 decoder among 8 requesters.
- Selects one requester, holds the grant until the requester releases or is pre-empted, and drives the decoder select lines (x, y, z, en) with the granted index.
- Sits directly in front of the decoder instance; the decoder output w[7:0] becomes the one-hot grant bus.
- Also exports a registered one-hot grant so downstream logic need not tap the decoder.

Parameters:
- MAX_HOLD, 16: maximum consecutive GRANT cycles before pre-emption when others are waiting. 0 disables pre-emption. Legal range 0..255.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous reset, active-low.
- req, input, 8: request per requester; requester i holds req[i] high for the whole time it needs the resource.
- gnt, output, 8: registered one-hot grant; all zeros when no grant.
- gnt_idx, output, 3: index of the current or last granted requester.
- gnt_valid, output, 1: high while a grant is active.
- sel_x, output, 1: gnt_idx[2], decoder MSB select.
- sel_y, output, 1: gnt_idx[1].
- sel_z, output, 1: gnt_idx[0], decoder LSB select.
- sel_en, output, 1: equals gnt_valid; decoder enable.
- preempt, output, 1: one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (rst_n low at a rising clk edge):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, sel_*=0, preempt=0, ptr=0, hold_cnt=0.
  - Asynchronous rst_n transitions have no effect until the next edge.
  - Reset mid-GRANT drops gnt on that same edge; no preempt pulse is generated.
- All outputs are registered. sel_x/y/z/en are direct copies of registered state, with no added latency.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
  - Next edge: gnt_idx=winner, gnt=1<<winner, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled to gnt visible is 1 cycle.
- GRANT (holder h = gnt_idx):
  - Release: if req[h]==0, then on the next edge gnt=0, gnt_valid=0, ptr=(h+1) mod 8, state=IDLE. gnt_idx keeps h.
  - Pre-emption: if MAX_HOLD≠0, req[h]==1, hold_cnt==MAX_HOLD-1, and (req & ~(1<<h))≠0, then on the next edge apply the same actions as release and pulse preempt=1 for one cycle.
  - Otherwise stay in GRANT. hold_cnt increments and saturates at MAX_HOLD-1, so a lone holder keeps the grant indefinitely.
  - A new requester arriving while the counter is saturated triggers pre-emption on the next evaluation.
- Turnaround: every grant change passes through exactly one IDLE cycle with gnt_valid=0. The decoder therefore never sees two enabled indices back to back.
- Requests by other requesters during GRANT are ignored except for the pre-emption test. There is no queuing; requests are level-sensitive only.
- Wrap-around: ptr=7+1 wraps to 0. The winner search wraps modulo 8.
- Simultaneous release and pre-emption conditions: release takes priority and preempt stays 0.
- hold_cnt width is 8 bits.
- Invariants, checked every cycle:
  - gnt == (gnt_valid ? 1<<gnt_idx : 0).
  - $onehot0(gnt).
  - sel_en == gnt_valid.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles with req=8'hFF, then release reset → gnt=0 throughout reset. Cycle 1 after reset: gnt=8'h01, gnt_idx=0, sel_x/y/z/en=0/0/0/1.
- Rotation: req=8'hFF held, each holder drops its req bit 3 cycles after grant and re-raises it 1 cycle later → grants 0,1,2,…,7,0 in order, one gnt_valid=0 cycle between each, wrap from 7 to 0.
- Fairness skip: ptr=3, req=8'b1000_0010 → grant 7; after 7 releases → grant 1.
- Pre-emption (MAX_HOLD=4): req[2] held, req[5] raised at grant+1 → after 4 GRANT cycles preempt=1 for one cycle, gnt=0 for 1 cycle, then gnt=8'h20.
- Lone holder: MAX_HOLD=4, only req[6] high for 20 cycles → gnt=8'h40 continuous, preempt never asserted. Raising req[1] at cycle 20 → preempt on the next edge, then grant 1.
- Reset mid-grant: rst_n=0 while gnt=8'h10 → next edge gnt=0, preempt=0, ptr=0. After reset with req=8'h11 → grant 0 (not 4).
